rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
Power-up reset sequencer for the Segway, downstream of the reset synchronizer; its RST_n input is the synchronized system reset. It staggers reset release: it holds the inertial sensor in reset, starts sensor init, and waits for init-done with timeout and retry. It then releases the balance controller and only afterwards permits motor drive. Unrecoverable sensor problems latch a fault that disables the drive.

Parameters:
CNT_W, 17, width of shared cycle counter; every *_CYC value must be ≤ 2^CNT_W
POR_CYC, 1024, clocks sensor held in reset after entry to HOLD
TMO_CYC, 65536, clocks allowed for init_done after init_strt
SETTLE_CYC, 256, clocks between ctrl_rst_n release and RUN
MAX_RETRY, 3, sensor-init retries before FAULT (retry counter 2 bits minimum, width = clog2(MAX_RETRY+1))

Ports:
clk  in  1  system clock; all logic on posedge
RST_n  in  1  reset, asynchronous, active-low; driven by synchronizer (negedge-released, giving half-cycle margin)
soft_rst  in  1  synchronous restart request, level
init_done  in  1  sensor init complete, level, synchronous
sns_fail  in  1  sensor failure flag, synchronous
en_req  in  1  rider/enable request, synchronous
sns_rst_n  out  1  inertial sensor reset, active-low
init_strt  out  1  one-cycle pulse starting sensor init
ctrl_rst_n  out  1  balance controller reset, active-low
drv_en  out  1  motor drive enable
sys_rdy  out  1  high in RUN
fault  out  1  latched fault
retry_cnt  out  clog2(MAX_RETRY+1)  retries used

Behaviour:
- All outputs registered (Moore). Async RST_n low: state=HOLD, cnt=0, retry_cnt=0, all outputs 0.
- Priority per edge: RST_n > soft_rst > sns_fail > state logic.
- soft_rst high at an edge: next state HOLD, cnt=0, retry_cnt=0, all outputs 0, including fault clear.
- HOLD:
  - sns_rst_n=0, ctrl_rst_n=0. cnt increments.
  - At edge with cnt==POR_CYC-1: go to SNS_INIT, cnt=0, sns_rst_n←1, init_strt←1.
- SNS_INIT:
  - init_strt high only for the first cycle in state.
  - cnt increments each cycle.
  - init_done sampled high: go to CTRL_REL, cnt=0, ctrl_rst_n←1.
  - Else at cnt==TMO_CYC-1, if retry_cnt<MAX_RETRY: retry_cnt++, go to HOLD (sns_rst_n←0, cnt=0).
  - Else at cnt==TMO_CYC-1: go to FAULT.
  - init_done in the timeout cycle: done wins.
  - init_done already high at entry is accepted at the first edge in state. init_strt still pulses.
- CTRL_REL: cnt increments. At cnt==SETTLE_CYC-1: go to RUN, sys_rdy←1.
- RUN: drv_en←en_req each edge (one-cycle latency). sys_rdy=1.
- sns_fail in SNS_INIT/CTRL_REL/RUN: go to FAULT. sns_fail ignored in HOLD.
- FAULT:
  - Outputs take these values on the entry edge: drv_en=0, sys_rdy=0, fault=1, init_strt=0.
  - sns_rst_n and ctrl_rst_n keep their values.
  - Exit only via RST_n or soft_rst. en_req ignored.
- drv_en can be 1 only in RUN. ctrl_rst_n=1 implies sns_rst_n=1.
- cnt never wraps; it is cleared on every state change.
- RST_n low mid-sequence: immediate async return to reset values. Sequence restarts from HOLD after release.

Test Plan:
(POR_CYC=8, TMO_CYC=20, SETTLE_CYC=4, MAX_RETRY=2 unless stated)
- Nominal power-up: release RST_n, init_done high 5 cycles after init_strt, en_req=1.
  - Expect sns_rst_n↑ at posedge 8 and init_strt high exactly one cycle.
  - Expect ctrl_rst_n↑ one edge after init_done, sys_rdy↑ 4 edges later, drv_en↑ on the following edge.
- Timeout with recovery: init_done held 0 for two attempts, then high.
  - Expect sns_rst_n low again 20 cycles after each init_strt, retry_cnt 1 then 2.
  - Expect three init_strt pulses total, then RUN.
- Retry exhaustion: init_done never asserts.
  - Expect FAULT after 3 timeouts: fault=1, retry_cnt=2, drv_en=0.
  - Expect the state held indefinitely with en_req=1.
- Simultaneous events:
  - init_done on the cnt==19 cycle: expect CTRL_REL, not a retry.
  - sns_fail with soft_rst in RUN: expect HOLD, fault=0.
- Runtime fault: sns_fail one-cycle pulse in RUN with drv_en=1.
  - Expect drv_en=0 and fault=1 at the next edge.
  - Expect ctrl_rst_n to stay 1.
- Mid-sequence resets:
  - RST_n low in CTRL_REL: expect outputs 0 asynchronously, before the next clk.
  - soft_rst in FAULT: expect fault cleared and a full re-sequence with sns_rst_n↑ 8 edges later.

Source files
------------

// File: rtl/rst_sequencer.sv
// Power-up reset sequencer: staggers sensor reset, sensor init (with timeout and retry),
// controller reset release and motor-drive permission. A latched fault disables the drive.
module rst_sequencer #(
  parameter int CNT_W      = 17,
  parameter int POR_CYC    = 1024,
  parameter int TMO_CYC    = 65536,
  parameter int SETTLE_CYC = 256,
  parameter int MAX_RETRY  = 3,
  localparam int RW        = $clog2(MAX_RETRY + 1)
) (
  input  logic          clk,
  input  logic          RST_n,
  input  logic          soft_rst,
  input  logic          init_done,
  input  logic          sns_fail,
  input  logic          en_req,
  output logic          sns_rst_n,
  output logic          init_strt,
  output logic          ctrl_rst_n,
  output logic          drv_en,
  output logic          sys_rdy,
  output logic          fault,
  output logic [RW-1:0] retry_cnt
);

  typedef enum logic [2:0] {
    HOLD,
    SNS_INIT,
    CTRL_REL,
    RUN,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments throughout, so every decision below sees the
  // pre-edge values of state, cnt and the outputs it also updates.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state      <= HOLD;
      cnt        <= '0;
      retry_cnt  <= '0;
      sns_rst_n  <= 1'b0;
      init_strt  <= 1'b0;
      ctrl_rst_n <= 1'b0;
      drv_en     <= 1'b0;
      sys_rdy    <= 1'b0;
      fault      <= 1'b0;
    end else if (soft_rst) begin
      state      <= HOLD;
      cnt        <= '0;
      retry_cnt  <= '0;
      sns_rst_n  <= 1'b0;
      init_strt  <= 1'b0;
      ctrl_rst_n <= 1'b0;
      drv_en     <= 1'b0;
      sys_rdy    <= 1'b0;
      fault      <= 1'b0;
    end else if (sns_fail && (state == SNS_INIT || state == CTRL_REL || state == RUN)) begin
      // Sensor resets are left as they are; only the drive path is shut down.
      state     <= FAULT;
      cnt       <= '0;
      init_strt <= 1'b0;
      drv_en    <= 1'b0;
      sys_rdy   <= 1'b0;
      fault     <= 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == POR_LAST) begin
            state     <= SNS_INIT;
            cnt       <= '0;
            sns_rst_n <= 1'b1;
            init_strt <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SNS_INIT: begin
          init_strt <= 1'b0;
          // init_done is checked first so a completion in the timeout cycle still counts.
          if (init_done) begin
            state      <= CTRL_REL;
            cnt        <= '0;
            ctrl_rst_n <= 1'b1;
          end else if (cnt == TMO_LAST) begin
            cnt <= '0;
            if (retry_cnt < RETRY_MAX) begin
              state     <= HOLD;
              retry_cnt <= retry_cnt + 1'b1;
              sns_rst_n <= 1'b0;
            end else begin
              state   <= FAULT;
              drv_en  <= 1'b0;
              sys_rdy <= 1'b0;
              fault   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CTRL_REL: begin
          if (cnt == SETTLE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            sys_rdy <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          sys_rdy <= 1'b1;
          drv_en  <= en_req;
        end

        FAULT: begin
          init_strt <= 1'b0;
          drv_en    <= 1'b0;
          sys_rdy   <= 1'b0;
          fault     <= 1'b1;
        end

        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
